// File: rtl/ibuffer_pkg.sv
// Shared frontend types and constants for the instruction buffer.
package ibuffer_pkg;

    localparam int INST_W      = 32;
    localparam int PC_W        = 64;
    localparam int FETCH_W     = 128;
    localparam int FETCH_INSTS = 4;
    localparam int FETCH_BYTES = 16;

    // One queued instruction together with its own PC.
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } ibuf_entry_t;

    // One compacted lane produced by the fetch block unpacker.
    typedef struct packed {
        logic        valid;
        ibuf_entry_t entry;
    } fetch_lane_t;

    // PC of a slot inside the 16-byte fetch block containing base.
    function automatic logic [PC_W-1:0] slot_pc(input logic [PC_W-1:0] base,
                                                input logic [1:0]      slot);
        return (base & {{(PC_W-4){1'b1}}, 4'b0000}) + {{(PC_W-4){1'b0}}, slot, 2'b00};
    endfunction

endpackage

// File: rtl/ibuffer_if.sv
// Fetch-side and decode-side signals of the instruction buffer.
interface ibuffer_if #(parameter int DEPTH = 16);
    import ibuffer_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                redirect_valid;
    logic                fetch_data_valid;
    logic [FETCH_W-1:0]  fetch_data;
    logic [PC_W-1:0]     fetch_pc;
    logic                fetch_inst;
    logic                ibuf_inst_valid;
    logic [INST_W-1:0]   ibuf_inst;
    logic [PC_W-1:0]     ibuf_pc;
    logic                ibuf_inst_ready;
    logic [CNT_W-1:0]    ibuf_count;

    // Frontend/backend side that feeds blocks and consumes instructions.
    modport master (
        output redirect_valid, fetch_data_valid, fetch_data, fetch_pc, ibuf_inst_ready,
        input  fetch_inst, ibuf_inst_valid, ibuf_inst, ibuf_pc, ibuf_count
    );

    // The buffer itself.
    modport slave (
        input  redirect_valid, fetch_data_valid, fetch_data, fetch_pc, ibuf_inst_ready,
        output fetch_inst, ibuf_inst_valid, ibuf_inst, ibuf_pc, ibuf_count
    );

    // Passive observer.
    modport monitor (
        input redirect_valid, fetch_data_valid, fetch_data, fetch_pc, ibuf_inst_ready,
        input fetch_inst, ibuf_inst_valid, ibuf_inst, ibuf_pc, ibuf_count
    );

endinterface

// File: rtl/ibuffer_chk.sv
// Protocol checker: upstream must never deliver a block that does not fit.
module ibuffer_chk
    import ibuffer_pkg::*;
#(
    parameter int DEPTH = 16
)(
    input  logic       clock,
    input  logic       reset_n,
    ibuffer_if.monitor bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0] n_s;
    logic [CNT_W-1:0] free_s;

    // Block size and space left after this cycle's dequeue.
    always_comb begin
        n_s    = CNT_W'(3'd4 - {1'b0, bus.fetch_pc[3:2]});
        free_s = CNT_W'(DEPTH) - bus.ibuf_count + CNT_W'(bus.ibuf_inst_valid && bus.ibuf_inst_ready);
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        (bus.fetch_data_valid && !bus.redirect_valid) |-> (n_s <= free_s));

endmodule

// File: rtl/ibuffer_fetch_block_unpack.sv
// Splits a 128-bit fetch block into compacted lanes starting at the fetch PC slot.
module ibuffer_fetch_block_unpack
    import ibuffer_pkg::*;
(
    input  logic [FETCH_W-1:0]                fetch_data,
    input  logic [PC_W-1:0]                   fetch_pc,
    output fetch_lane_t [FETCH_INSTS-1:0]     lanes_s,
    output logic [2:0]                        n_s
);

    logic [2:0] slot_s;

    // Lane j carries slot (s + j); lanes past slot 3 are empty.
    always_comb begin
        n_s     = 3'd4 - {1'b0, fetch_pc[3:2]};
        slot_s  = 3'd0;
        lanes_s = '0;
        for (int j = 0; j < FETCH_INSTS; j++) begin
            slot_s = {1'b0, fetch_pc[3:2]} + 3'(j);
            if (slot_s <= 3'd3) begin
                lanes_s[j].valid      = 1'b1;
                lanes_s[j].entry.inst = fetch_data[{slot_s[1:0], 5'b00000} +: INST_W];
                lanes_s[j].entry.pc   = slot_pc(fetch_pc, slot_s[1:0]);
            end else begin
                lanes_s[j] = '0;
            end
        end
    end

endmodule

// File: rtl/ibuffer.sv
// Instruction buffer: circular queue of {inst, pc} between fetch and decode.
module ibuffer
    import ibuffer_pkg::*;
#(
    parameter int DEPTH = 16
)(
    input  logic      clock,
    input  logic      reset_n,
    ibuffer_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(DEPTH);

    ibuf_entry_t                  mem_q [DEPTH];
    ibuf_entry_t                  mem_d [DEPTH];
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             count_q, count_d;
    fetch_lane_t [FETCH_INSTS-1:0] lanes_s;
    logic [2:0]                   n_s;
    logic [PTR_W-1:0]             n_ext_s;
    logic [PTR_W-1:0]             free_s;
    logic                         valid_s;
    logic                         deq_s;
    logic                         enq_s;

    ibuffer_fetch_block_unpack u_unpack (
        .fetch_data (bus.fetch_data),
        .fetch_pc   (bus.fetch_pc),
        .lanes_s    (lanes_s),
        .n_s        (n_s)
    );

    // Handshakes and next pointer/count state; a redirect empties the queue.
    always_comb begin
        valid_s = (count_q != PTR_W'(0)) && !bus.redirect_valid;
        deq_s   = valid_s && bus.ibuf_inst_ready;
        n_ext_s = PTR_W'(n_s);
        free_s  = PTR_W'(DEPTH) - count_q + PTR_W'(deq_s);
        // A block that does not fit is dropped whole, leaving the pointers alone.
        enq_s   = bus.fetch_data_valid && !bus.redirect_valid && (n_ext_s <= free_s);
        if (bus.redirect_valid) begin
            rd_ptr_d = PTR_W'(0);
            wr_ptr_d = PTR_W'(0);
            count_d  = PTR_W'(0);
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(deq_s);
            wr_ptr_d = enq_s ? (wr_ptr_q + n_ext_s) : wr_ptr_q;
            count_d  = count_q + (enq_s ? n_ext_s : PTR_W'(0)) - PTR_W'(deq_s);
        end
    end

    // Storage write: lane j lands at index (wr_ptr + j) modulo DEPTH.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            for (int j = 0; j < FETCH_INSTS; j++) begin
                mem_d[i] = (enq_s && lanes_s[j].valid &&
                            ((wr_ptr_q[IDX_W-1:0] + IDX_W'(j)) == IDX_W'(i)))
                           ? lanes_s[j].entry : mem_d[i];
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= PTR_W'(0);
            wr_ptr_q <= PTR_W'(0);
            count_q  <= PTR_W'(0);
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Head is read from registered storage only, so fetch data never reaches decode in one cycle.
    assign bus.ibuf_inst_valid = valid_s;
    assign bus.ibuf_inst       = mem_q[rd_ptr_q[IDX_W-1:0]].inst;
    assign bus.ibuf_pc         = mem_q[rd_ptr_q[IDX_W-1:0]].pc;
    assign bus.ibuf_count      = count_q;
    assign bus.fetch_inst      = (PTR_W'(DEPTH) - count_q) >= PTR_W'(FETCH_INSTS);

endmodule

// File: tb/tb_ibuffer.sv
// Self-checking bench for ibuffer with a scoreboard of expected {inst, pc}.
module tb_ibuffer;
    import ibuffer_pkg::*;

    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic        clock;
    logic        reset_n;
    int          checks;
    int          errors;
    ibuf_entry_t exp_q[$];

    ibuffer_if #(.DEPTH(DEPTH)) bus ();

    ibuffer #(.DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    ibuffer_chk #(.DEPTH(DEPTH)) chk (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.monitor)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive a fetch block and record the entries it should produce.
    task automatic push_block(input logic [PC_W-1:0] pc, input logic [FETCH_W-1:0] data);
        ibuf_entry_t e;
        bus.fetch_data_valid = 1'b1;
        bus.fetch_pc         = pc;
        bus.fetch_data       = data;
        for (int i = int'(pc[3:2]); i < FETCH_INSTS; i++) begin
            e.inst = data[32*i +: 32];
            e.pc   = {pc[PC_W-1:4], 4'h0} + 64'(4 * i);
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        #1;
        checks++; if (bus.fetch_inst !== 1'b1) begin errors++; $display("FAIL reset_fetch_inst: got %b want 1", bus.fetch_inst); end
        checks++; if (bus.ibuf_inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.ibuf_inst_valid); end
        checks++; if (bus.ibuf_count !== CNT_W'(0)) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.ibuf_count); end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_aligned();
        ibuf_entry_t e;
        @(negedge clock);
        push_block(64'h8000_0000, {32'h4, 32'h3, 32'h2, 32'h1});
        bus.ibuf_inst_ready = 1'b1;
        #1;
        checks++; if (bus.ibuf_inst_valid !== 1'b0) begin errors++; $display("FAIL aligned_latency: valid got %b want 0", bus.ibuf_inst_valid); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            bus.fetch_data_valid = 1'b0;
            #1;
            checks++;
            if (bus.ibuf_inst_valid !== 1'b1 || exp_q.size() == 0) begin
                errors++; $display("FAIL aligned_valid: got %b want 1 (k=%0d)", bus.ibuf_inst_valid, k);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (bus.ibuf_inst !== e.inst || bus.ibuf_pc !== e.pc || bus.ibuf_inst !== 32'(k + 1))
                    begin errors++; $display("FAIL aligned_order: got %h/%h want %h/%h", bus.ibuf_inst, bus.ibuf_pc, e.inst, e.pc); end
            end
        end
        @(negedge clock);
        bus.ibuf_inst_ready = 1'b0;
        #1;
        checks++; if (bus.ibuf_inst_valid !== 1'b0 || bus.ibuf_count !== CNT_W'(0))
            begin errors++; $display("FAIL aligned_empty: valid %b count %0d want 0 0", bus.ibuf_inst_valid, bus.ibuf_count); end
    endtask

    task automatic test_unaligned();
        ibuf_entry_t e;
        @(negedge clock);
        push_block(64'h8000_0008, {32'h44, 32'h33, 32'h22, 32'h11});
        @(negedge clock);
        bus.fetch_data_valid = 1'b0;
        #1;
        checks++; if (bus.ibuf_count !== CNT_W'(2)) begin errors++; $display("FAIL unaligned_count: got %0d want 2", bus.ibuf_count); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            bus.ibuf_inst_ready = 1'b1;
            #1;
            checks++;
            if (bus.ibuf_inst_valid !== 1'b1 || exp_q.size() == 0) begin
                errors++; $display("FAIL unaligned_valid: got %b want 1", bus.ibuf_inst_valid);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (bus.ibuf_inst !== e.inst || bus.ibuf_pc !== e.pc || bus.ibuf_pc !== (64'h8000_0008 + 64'(4 * k)))
                    begin errors++; $display("FAIL unaligned_order: got %h/%h want %h/%h", bus.ibuf_inst, bus.ibuf_pc, e.inst, e.pc); end
            end
        end
        @(negedge clock);
        bus.ibuf_inst_ready = 1'b0;
    endtask

    task automatic test_fill();
        ibuf_entry_t e;
        bus.ibuf_inst_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (k < 4) push_block(64'h1000_0000 + 64'(16 * k), {32'(k * 16 + 4), 32'(k * 16 + 3), 32'(k * 16 + 2), 32'(k * 16 + 1)});
            else bus.fetch_data_valid = 1'b0;
            #1;
            if (k > 0) begin
                checks++; if (bus.ibuf_count !== CNT_W'(4 * k)) begin errors++; $display("FAIL fill_count: got %0d want %0d", bus.ibuf_count, 4 * k); end
                checks++; if (bus.fetch_inst !== (k < 4)) begin errors++; $display("FAIL fill_fetch_inst: got %b want %b", bus.fetch_inst, k < 4); end
            end
        end
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            bus.ibuf_inst_ready = 1'b1;
            #1;
            if (k == 3) begin checks++; if (bus.fetch_inst !== 1'b0) begin errors++; $display("FAIL fill_after3: fetch_inst got %b want 0", bus.fetch_inst); end end
            if (k == 4) begin checks++; if (bus.fetch_inst !== 1'b1) begin errors++; $display("FAIL fill_after4: fetch_inst got %b want 1", bus.fetch_inst); end end
            checks++;
            if (bus.ibuf_inst_valid !== 1'b1 || exp_q.size() == 0) begin
                errors++; $display("FAIL fill_valid: got %b want 1 (k=%0d)", bus.ibuf_inst_valid, k);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (bus.ibuf_inst !== e.inst || bus.ibuf_pc !== e.pc)
                    begin errors++; $display("FAIL fill_order: got %h/%h want %h/%h", bus.ibuf_inst, bus.ibuf_pc, e.inst, e.pc); end
            end
        end
        @(negedge clock);
        bus.ibuf_inst_ready = 1'b0;
    endtask

    task automatic test_wrap();
        ibuf_entry_t e;
        // Flush to zero the pointers, then move rd/wr to 14.
        @(negedge clock);
        bus.redirect_valid = 1'b1;
        @(negedge clock);
        bus.redirect_valid = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            push_block(64'h2000_0000 + 64'(16 * k) + ((k == 3) ? 64'h8 : 64'h0),
                       {32'(k * 16 + 4), 32'(k * 16 + 3), 32'(k * 16 + 2), 32'(k * 16 + 1)});
            @(negedge clock);
        end
        bus.fetch_data_valid = 1'b0;
        for (int k = 0; k < 14; k++) begin
            bus.ibuf_inst_ready = 1'b1;
            #1;
            if (bus.ibuf_inst_valid === 1'b1 && exp_q.size() != 0) e = exp_q.pop_front();
            @(negedge clock);
        end
        checks++; if (bus.ibuf_count !== CNT_W'(0)) begin errors++; $display("FAIL wrap_setup: count got %0d want 0", bus.ibuf_count); end
        bus.ibuf_inst_ready = 1'b0;
        // wr_ptr 14 -> 26 with three aligned blocks.
        for (int k = 0; k < 3; k++) begin
            push_block(64'h2000_1000 + 64'(16 * k), {32'(k * 16 + 'h104), 32'(k * 16 + 'h103), 32'(k * 16 + 'h102), 32'(k * 16 + 'h101)});
            @(negedge clock);
        end
        // Concurrent enqueue of 4 and dequeue of 1 at count 12.
        push_block(64'h2000_1030, {32'h134, 32'h133, 32'h132, 32'h131});
        bus.ibuf_inst_ready = 1'b1;
        #1;
        checks++; if (bus.ibuf_count !== CNT_W'(12)) begin errors++; $display("FAIL wrap_count12: got %0d want 12", bus.ibuf_count); end
        e = exp_q.pop_front();
        checks++; if (bus.ibuf_inst_valid !== 1'b1 || bus.ibuf_inst !== e.inst || bus.ibuf_pc !== e.pc)
            begin errors++; $display("FAIL wrap_concurrent: got %b %h/%h want 1 %h/%h", bus.ibuf_inst_valid, bus.ibuf_inst, bus.ibuf_pc, e.inst, e.pc); end
        @(negedge clock);
        bus.fetch_data_valid = 1'b0;
        bus.ibuf_inst_ready  = 1'b0;
        #1;
        checks++; if (bus.ibuf_count !== CNT_W'(15)) begin errors++; $display("FAIL wrap_count15: got %0d want 15", bus.ibuf_count); end
        for (int k = 0; k < 15; k++) begin
            @(negedge clock);
            bus.ibuf_inst_ready = 1'b1;
            #1;
            checks++;
            if (bus.ibuf_inst_valid !== 1'b1 || exp_q.size() == 0) begin
                errors++; $display("FAIL wrap_valid: got %b want 1 (k=%0d)", bus.ibuf_inst_valid, k);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (bus.ibuf_inst !== e.inst || bus.ibuf_pc !== e.pc)
                    begin errors++; $display("FAIL wrap_order: got %h/%h want %h/%h", bus.ibuf_inst, bus.ibuf_pc, e.inst, e.pc); end
            end
        end
        @(negedge clock);
        bus.ibuf_inst_ready = 1'b0;
    endtask

    task automatic test_redirect();
        ibuf_entry_t e;
        push_block(64'h3000_0000, {32'h4, 32'h3, 32'h2, 32'h1});
        @(negedge clock);
        push_block(64'h3000_0010, {32'h14, 32'h13, 32'h12, 32'h11});
        @(negedge clock);
        push_block(64'h3000_0028, {32'h24, 32'h23, 32'h22, 32'h21});
        @(negedge clock);
        bus.fetch_data_valid = 1'b0;
        #1;
        checks++; if (bus.ibuf_count !== CNT_W'(10)) begin errors++; $display("FAIL redirect_setup: count got %0d want 10", bus.ibuf_count); end
        @(negedge clock);
        bus.redirect_valid   = 1'b1;
        bus.fetch_data_valid = 1'b1;
        bus.fetch_pc         = 64'h3000_0100;
        bus.fetch_data       = {32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hDEAD};
        bus.ibuf_inst_ready  = 1'b1;
        #1;
        checks++; if (bus.ibuf_inst_valid !== 1'b0) begin errors++; $display("FAIL redirect_mask: valid got %b want 0", bus.ibuf_inst_valid); end
        exp_q.delete();
        @(negedge clock);
        bus.redirect_valid = 1'b0;
        push_block(64'h4000_0024, {32'h54, 32'h53, 32'h52, 32'h51});
        #1;
        checks++; if (bus.ibuf_count !== CNT_W'(0)) begin errors++; $display("FAIL redirect_count: got %0d want 0", bus.ibuf_count); end
        checks++; if (bus.fetch_inst !== 1'b1) begin errors++; $display("FAIL redirect_fetch_inst: got %b want 1", bus.fetch_inst); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            bus.fetch_data_valid = 1'b0;
            #1;
            checks++;
            if (bus.ibuf_inst_valid !== 1'b1 || exp_q.size() == 0) begin
                errors++; $display("FAIL redirect_valid: got %b want 1 (k=%0d)", bus.ibuf_inst_valid, k);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (bus.ibuf_inst !== e.inst || bus.ibuf_pc !== e.pc || (k == 0 && bus.ibuf_pc !== 64'h4000_0024))
                    begin errors++; $display("FAIL redirect_order: got %h/%h want %h/%h", bus.ibuf_inst, bus.ibuf_pc, e.inst, e.pc); end
            end
        end
        @(negedge clock);
        bus.ibuf_inst_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        push_block(64'h5000_0000, {32'h4, 32'h3, 32'h2, 32'h1});
        @(negedge clock);
        push_block(64'h5000_0010, {32'h14, 32'h13, 32'h12, 32'h11});
        @(negedge clock);
        bus.fetch_data_valid = 1'b0;
        #1;
        checks++; if (bus.ibuf_count !== CNT_W'(8)) begin errors++; $display("FAIL resetmid_setup: count got %0d want 8", bus.ibuf_count); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (bus.fetch_inst !== 1'b1) begin errors++; $display("FAIL resetmid_fetch_inst: got %b want 1", bus.fetch_inst); end
        checks++; if (bus.ibuf_inst_valid !== 1'b0) begin errors++; $display("FAIL resetmid_valid: got %b want 0", bus.ibuf_inst_valid); end
        checks++; if (bus.ibuf_count !== CNT_W'(0)) begin errors++; $display("FAIL resetmid_count: got %0d want 0", bus.ibuf_count); end
        exp_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        checks               = 0;
        errors               = 0;
        reset_n              = 1'b0;
        bus.redirect_valid   = 1'b0;
        bus.fetch_data_valid = 1'b0;
        bus.fetch_data       = '0;
        bus.fetch_pc         = '0;
        bus.ibuf_inst_ready  = 1'b0;
        test_reset();
        test_aligned();
        test_unaligned();
        test_fill();
        test_wrap();
        test_redirect();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
